// File: rtl/cc_fill_deserializer.sv
// Reassembles 8-beat critical-word-first MEM R bursts into 512-bit lines for the SRAM fill port.
// Latency: line presented 1 cycle after the accepted final beat.
// Backpressure: beat_stall_o holds off the final beat while an earlier line still waits on fill_ready_i.
//
// Ports:
//   clk, rst                        clock, asynchronous active-high reset
//   miss_wren_i/miss_wdata_i        push {tag, index, offset} at AR issue
//   miss_afull_o/miss_full_o        miss-info FIFO occupancy flags
//   beat_valid_i/data_i/last_i      accepted MEM R beat (snooped)
//   beat_stall_o                    combinational; top masks mem_rready with it
//   fill_valid_o/fill_ready_i       line handshake to SRAM fill port
//   fill_tag_o/index_o/data_o       registered line payload
//   err_o                           sticky protocol error
module cc_fill_deserializer #(
    parameter int TAG_W      = 17,
    parameter int IDX_W      = 9,
    parameter int MISS_DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     miss_wren_i,
    input  logic [TAG_W+IDX_W+2:0]   miss_wdata_i,
    output logic                     miss_afull_o,
    output logic                     miss_full_o,
    input  logic                     beat_valid_i,
    input  logic [63:0]              beat_data_i,
    input  logic                     beat_last_i,
    output logic                     beat_stall_o,
    output logic                     fill_valid_o,
    input  logic                     fill_ready_i,
    output logic [TAG_W-1:0]         fill_tag_o,
    output logic [IDX_W-1:0]         fill_index_o,
    output logic [511:0]             fill_data_o,
    output logic                     err_o
);

    localparam int MW = TAG_W + IDX_W + 3;
    localparam int PW = (MISS_DEPTH > 1) ? $clog2(MISS_DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef enum logic {S_IDLE, S_FILL} state_t;

    logic [MW-1:0]    r_mem [MISS_DEPTH];
    logic [PW-1:0]    r_wptr, r_rptr;
    logic [CW-1:0]    r_count;
    state_t           r_state;
    logic [2:0]       r_cnt;
    logic [511:0]     r_buf;
    logic             r_fvld;
    logic [TAG_W-1:0] r_ftag;
    logic [IDX_W-1:0] r_fidx;
    logic [511:0]     r_fdata;
    logic             r_err;

    logic [MW-1:0]    w_head;
    logic [2:0]       w_off;
    logic [2:0]       w_slot;
    logic             w_full;
    logic             w_stall;
    logic             w_accept;
    logic             w_end;
    logic             w_load;
    logic             w_push;
    logic             w_err_evt;
    logic [CW-1:0]    w_count_nxt;
    logic [511:0]     w_line;

    assign w_head   = r_mem[r_rptr];
    assign w_off    = w_head[2:0];
    // Wrap arithmetic in 3 bits gives the critical-word-first slot order.
    assign w_slot   = w_off + r_cnt;
    assign w_full   = (r_count == CW'(MISS_DEPTH));
    // Only the final beat needs the output register, so only it is held off.
    assign w_stall  = (r_state == S_FILL) && (r_cnt == 3'd7) && r_fvld && !fill_ready_i;
    assign w_accept = beat_valid_i && (r_state == S_FILL) && !w_stall;
    assign w_end    = w_accept && (beat_last_i || (r_cnt == 3'd7));
    assign w_load   = w_accept && (r_cnt == 3'd7);
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign w_push   = miss_wren_i && (!w_full || w_end);

    assign w_count_nxt = r_count + CW'(w_push) - CW'(w_end);

    assign w_err_evt = (beat_valid_i && ((r_state == S_IDLE) || w_stall))
                     || (miss_wren_i && w_full && !w_end)
                     || (w_accept && beat_last_i && (r_cnt != 3'd7))
                     || (w_accept && !beat_last_i && (r_cnt == 3'd7));

    // Current beat merged into the partial line so the final beat lands in the output in one step.
    always_comb begin
        w_line = r_buf;
        w_line[64*w_slot +: 64] = beat_data_i;
    end

    // FIFO storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= miss_wdata_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_buf   <= '0;
            r_fvld  <= 1'b0;
            r_ftag  <= '0;
            r_fidx  <= '0;
            r_fdata <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_end)  r_rptr <= r_rptr + 1'b1;
            r_count <= w_count_nxt;
            r_state <= (w_count_nxt != '0) ? S_FILL : S_IDLE;

            if (w_end) begin
                r_cnt <= '0;
                r_buf <= '0;
            end else if (w_accept) begin
                r_cnt <= r_cnt + 3'd1;
                r_buf <= w_line;
            end

            // A new line can load in the same cycle the previous one is taken.
            if (w_load) begin
                r_fvld  <= 1'b1;
                r_ftag  <= w_head[MW-1 -: TAG_W];
                r_fidx  <= w_head[3 +: IDX_W];
                r_fdata <= w_line;
            end else if (fill_ready_i) begin
                r_fvld  <= 1'b0;
            end

            if (w_err_evt) r_err <= 1'b1;
        end
    end

    assign miss_afull_o = (r_count >= CW'(MISS_DEPTH - 1));
    assign miss_full_o  = w_full;
    assign beat_stall_o = w_stall;
    assign fill_valid_o = r_fvld;
    assign fill_tag_o   = r_ftag;
    assign fill_index_o = r_fidx;
    assign fill_data_o  = r_fdata;
    assign err_o        = r_err;

endmodule
